// File: rtl/final_nios2_proc_oci_pkg.sv
// Shared definitions for the OCI debug-capture-trace sequencer.
package final_nios2_proc_oci_pkg;

  localparam int unsigned DefSymW  = 3;
  localparam int unsigned DefSyms  = 10;
  localparam int unsigned DefCntW  = 4;
  localparam int unsigned DefDropW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StHold,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/final_nios2_proc_oci_sat_cnt.sv
// Up-counter with synchronous clear that sticks at all-ones.
module final_nios2_proc_oci_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/final_nios2_proc_oci_dct_ctrl.sv
// DCT buffer sequencer: packs trace symbols into frames, offers them on valid/ready,
// flushes the partial frame when the test ends.
module final_nios2_proc_oci_dct_ctrl
  import final_nios2_proc_oci_pkg::*;
#(
  parameter int unsigned SYM_W  = DefSymW,
  parameter int unsigned SYMS   = DefSyms,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned DROP_W = DefDropW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trace_enable,
  input  logic                  trace_valid,
  input  logic [SYM_W-1:0]      trace_sym,
  input  logic                  test_ending,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [SYM_W*SYMS-1:0] dct_buffer,
  output logic [CNT_W-1:0]      dct_count,
  output logic                  test_has_ended,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int unsigned BUF_W = SYM_W * SYMS;

  state_e state;
  logic   ending_q;
  logic   sym_in, accept, handshake, drop, ending;

  assign sym_in    = trace_enable & trace_valid;
  assign handshake = frame_valid & frame_ready;
  assign accept    = sym_in & ((state == StIdle) | (state == StFill)) & ~test_has_ended;
  assign drop      = sym_in & (state == StHold) & ~handshake;
  // A request seen while a frame is held must survive until that frame is delivered.
  assign ending    = test_ending | ending_q;

  final_nios2_proc_oci_sat_cnt #(
    .W(DROP_W)
  ) u_drop_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (drop),
    .clr    (1'b0),
    .count  (drop_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      ending_q       <= 1'b0;
      frame_valid    <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_has_ended <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (test_ending) ending_q <= 1'b1;
      if (drop) overflow <= 1'b1;
      unique case (state)
        StIdle, StFill: begin
          if (accept) begin
            for (int i = 0; i < SYMS; i++) begin
              if (CNT_W'(i) == dct_count) dct_buffer[i*SYM_W +: SYM_W] <= trace_sym;
            end
            dct_count <= dct_count + CNT_W'(1);
          end
          if (accept && (dct_count == CNT_W'(SYMS - 1))) begin
            frame_valid <= 1'b1;
            state       <= ending ? StFlush : StHold;
          end else if (ending) begin
            if (accept || (state == StFill)) begin
              frame_valid <= 1'b1;
              state       <= StFlush;
            end else begin
              state          <= StDone;
              test_has_ended <= 1'b1;
            end
          end else if (accept) begin
            state <= StFill;
          end
        end
        StHold: begin
          if (handshake) begin
            frame_valid <= 1'b0;
            dct_buffer  <= '0;
            dct_count   <= '0;
            if (sym_in) begin
              // Symbol arriving with the handshake starts the next frame.
              dct_buffer <= BUF_W'(trace_sym);
              dct_count  <= CNT_W'(1);
              if (ending) begin
                frame_valid <= 1'b1;
                state       <= StFlush;
              end else begin
                state <= StFill;
              end
            end else if (ending) begin
              state          <= StDone;
              test_has_ended <= 1'b1;
            end else begin
              state <= StIdle;
            end
          end
        end
        StFlush: begin
          if (handshake) begin
            frame_valid    <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            state          <= StDone;
            test_has_ended <= 1'b1;
          end
        end
        StDone: ;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
